// File: rtl/uart_cmd_rx.sv
// UART receiver (start, 8 data LSB first, spare, stop) feeding a 4-byte command
// frame assembler that emits one-cycle command strobes for the control block.
module uart_cmd_rx #(
  parameter int BIT_CYC = 868,
  parameter int TO_CYC  = 100000
) (
  input  logic        clk_sys,
  input  logic        rst_sys,
  input  logic        uart_rx,
  output logic        cmd_vld,
  output logic        cmd_wr,
  output logic [15:0] cmd_addr,
  output logic [7:0]  cmd_wdata,
  output logic        frm_err,
  output logic        rx_byte_vld,
  output logic [7:0]  rx_byte
);

  localparam int              TO_W    = $clog2(TO_CYC + 1);
  localparam logic [15:0]     HALF_LD = 16'(BIT_CYC / 2 - 1);
  localparam logic [15:0]     FULL_LD = 16'(BIT_CYC - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_SPARE, S_STOP} state_t;

  state_t          state, state_nxt;
  logic [15:0]     bit_cnt, bit_cnt_nxt;
  logic [2:0]      bit_idx, bit_idx_nxt;
  logic [7:0]      shift_reg, shift_reg_nxt;
  logic            byte_ok, byte_bad;
  logic            rx_meta, rx_sync, rx_prev, rx_fall;
  logic [1:0]      frm_idx;
  logic            hdr_wr;
  logic [7:0]      addr_hi, addr_lo;
  logic [TO_W-1:0] to_cnt;

  // rx_prev keeps tracking the line, so after a low stop bit no new start is
  // seen until the line has gone high again.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      rx_byte_vld <= 1'b0;
      frm_err     <= 1'b0;
      rx_byte     <= '0;
    end else begin
      state       <= state_nxt;
      bit_cnt     <= bit_cnt_nxt;
      bit_idx     <= bit_idx_nxt;
      shift_reg   <= shift_reg_nxt;
      rx_byte_vld <= byte_ok;
      frm_err     <= byte_bad;
      if (byte_ok) rx_byte <= shift_reg;
    end
  end

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    bit_idx_nxt   = bit_idx;
    shift_reg_nxt = shift_reg;
    byte_ok       = 1'b0;
    byte_bad      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (rx_fall) begin
          state_nxt   = S_START;
          bit_cnt_nxt = HALF_LD;
        end
      end
      S_START: begin
        if (bit_cnt == 16'd0) begin
          if (!rx_sync) begin
            state_nxt   = S_DATA;
            bit_cnt_nxt = FULL_LD;
            bit_idx_nxt = 3'd0;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          bit_cnt_nxt = bit_cnt - 16'd1;
        end
      end
      S_DATA: begin
        if (bit_cnt == 16'd0) begin
          shift_reg_nxt = {rx_sync, shift_reg[7:1]};
          bit_cnt_nxt   = FULL_LD;
          if (bit_idx == 3'd7) state_nxt = S_SPARE;
          else bit_idx_nxt = bit_idx + 3'd1;
        end else begin
          bit_cnt_nxt = bit_cnt - 16'd1;
        end
      end
      S_SPARE: begin
        if (bit_cnt == 16'd0) begin
          state_nxt   = S_STOP;
          bit_cnt_nxt = FULL_LD;
        end else begin
          bit_cnt_nxt = bit_cnt - 16'd1;
        end
      end
      S_STOP: begin
        // Back to IDLE at mid-stop so a back-to-back start edge is not missed.
        if (bit_cnt == 16'd0) begin
          byte_ok   = rx_sync;
          byte_bad  = ~rx_sync;
          state_nxt = S_IDLE;
        end else begin
          bit_cnt_nxt = bit_cnt - 16'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A received byte takes priority over a timeout landing in the same cycle.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      frm_idx   <= '0;
      hdr_wr    <= 1'b0;
      addr_hi   <= '0;
      addr_lo   <= '0;
      to_cnt    <= '0;
      cmd_vld   <= 1'b0;
      cmd_wr    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else begin
      cmd_vld <= 1'b0;
      if (rx_byte_vld) begin
        to_cnt <= '0;
        case (frm_idx)
          2'd0: begin
            if (rx_byte == 8'h82 || rx_byte == 8'h02) begin
              hdr_wr  <= rx_byte[7];
              frm_idx <= 2'd1;
            end
          end
          2'd1: begin
            addr_hi <= rx_byte;
            frm_idx <= 2'd2;
          end
          2'd2: begin
            addr_lo <= rx_byte;
            frm_idx <= 2'd3;
          end
          default: begin
            cmd_vld   <= 1'b1;
            cmd_wr    <= hdr_wr;
            cmd_addr  <= {addr_hi, addr_lo};
            cmd_wdata <= rx_byte;
            frm_idx   <= 2'd0;
          end
        endcase
      end else if (frm_err) begin
        frm_idx <= 2'd0;
        to_cnt  <= '0;
      end else if (frm_idx != 2'd0) begin
        if (to_cnt == TO_LAST) begin
          frm_idx <= 2'd0;
          to_cnt  <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: a table of serial frames with hand-computed
// command results, plus hand-written glitch and mid-frame reset sequences.
module tb_uart_cmd_rx;

  localparam int BIT_CYC = 16;
  localparam int TO_CYC  = 400;

  logic        clk_sys = 1'b0;
  logic        rst_sys = 1'b1;
  logic        uart_rx = 1'b1;
  logic        cmd_vld, cmd_wr, frm_err, rx_byte_vld;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata, rx_byte;

  always #5 clk_sys = ~clk_sys;

  uart_cmd_rx #(.BIT_CYC(BIT_CYC), .TO_CYC(TO_CYC)) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys), .uart_rx(uart_rx),
    .cmd_vld(cmd_vld), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .frm_err(frm_err),
    .rx_byte_vld(rx_byte_vld), .rx_byte(rx_byte)
  );

  typedef struct {
    int               nbytes;
    logic [0:7][7:0]  b;
    logic [7:0]       bad_stop;
    int               gap;
    int               to_after;
    int               exp_cmd;
    logic             exp_wr;
    logic [15:0]      exp_addr;
    logic [7:0]       exp_wdata;
    int               exp_bytes;
    int               exp_err;
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;

  // Pulse counters and the command captured at each strobe, sampled on negedge.
  int          cmd_cnt = 0, byte_cnt = 0, err_cnt = 0, lat_err = 0;
  logic        prev_bvld = 1'b0;
  logic        last_wr = 1'b0;
  logic [15:0] last_addr = '0;
  logic [7:0]  last_wdata = '0;

  always @(negedge clk_sys) begin
    if (cmd_vld) begin
      cmd_cnt    <= cmd_cnt + 1;
      last_wr    <= cmd_wr;
      last_addr  <= cmd_addr;
      last_wdata <= cmd_wdata;
      if (!prev_bvld) lat_err <= lat_err + 1;
    end
    if (rx_byte_vld) byte_cnt <= byte_cnt + 1;
    if (frm_err) err_cnt <= err_cnt + 1;
    prev_bvld <= rx_byte_vld;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] d, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (BIT_CYC) @(negedge clk_sys);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      repeat (BIT_CYC) @(negedge clk_sys);
    end
    uart_rx = ~^d;
    repeat (BIT_CYC) @(negedge clk_sys);
    uart_rx = stop_bit;
    repeat (BIT_CYC) @(negedge clk_sys);
    uart_rx = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    for (int i = 0; i < v.nbytes; i++) begin
      sendByte(v.b[i], ~v.bad_stop[i]);
      if (i == v.to_after) repeat (TO_CYC + 10) @(negedge clk_sys);
      else repeat (v.gap * BIT_CYC) @(negedge clk_sys);
    end
    repeat (3 * BIT_CYC) @(negedge clk_sys);
  endtask

  vec_t vecs[5];
  vec_t post;
  int   c0, b0, e0, l0;

  initial begin
    vecs[0] = '{nbytes: 4, b: {8'h82, 8'h00, 8'h02, 8'h42, 32'h0}, bad_stop: 8'h00, gap: 1,
                to_after: -1, exp_cmd: 1, exp_wr: 1'b1, exp_addr: 16'h0002, exp_wdata: 8'h42,
                exp_bytes: 4, exp_err: 0};
    vecs[1] = '{nbytes: 4, b: {8'h02, 8'h00, 8'h85, 8'h00, 32'h0}, bad_stop: 8'h00, gap: 0,
                to_after: -1, exp_cmd: 1, exp_wr: 1'b0, exp_addr: 16'h0085, exp_wdata: 8'h00,
                exp_bytes: 4, exp_err: 0};
    vecs[2] = '{nbytes: 5, b: {8'h55, 8'h82, 8'h00, 8'h04, 8'h55, 24'h0}, bad_stop: 8'h00, gap: 1,
                to_after: -1, exp_cmd: 1, exp_wr: 1'b1, exp_addr: 16'h0004, exp_wdata: 8'h55,
                exp_bytes: 5, exp_err: 0};
    vecs[3] = '{nbytes: 6, b: {8'h82, 8'h00, 8'h82, 8'h00, 8'h03, 8'h20, 16'h0}, bad_stop: 8'h00,
                gap: 1, to_after: 1, exp_cmd: 1, exp_wr: 1'b1, exp_addr: 16'h0003,
                exp_wdata: 8'h20, exp_bytes: 6, exp_err: 0};
    vecs[4] = '{nbytes: 6, b: {8'h82, 8'h00, 8'h82, 8'h00, 8'h06, 8'h03, 16'h0}, bad_stop: 8'h02,
                gap: 1, to_after: -1, exp_cmd: 1, exp_wr: 1'b1, exp_addr: 16'h0006,
                exp_wdata: 8'h03, exp_bytes: 5, exp_err: 1};

    repeat (5) @(negedge clk_sys);
    checkOutput("reset cmd_vld", 32'(cmd_vld), 32'h0);
    checkOutput("reset cmd_wr", 32'(cmd_wr), 32'h0);
    checkOutput("reset cmd_addr", 32'(cmd_addr), 32'h0);
    checkOutput("reset cmd_wdata", 32'(cmd_wdata), 32'h0);
    checkOutput("reset rx_byte", 32'(rx_byte), 32'h0);
    checkOutput("reset strobes", 32'({frm_err, rx_byte_vld}), 32'h0);
    rst_sys = 1'b0;
    repeat (4) @(negedge clk_sys);

    for (int i = 0; i < 5; i++) begin
      c0 = cmd_cnt; b0 = byte_cnt; e0 = err_cnt; l0 = lat_err;
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d cmd_vld count", i), 32'(cmd_cnt - c0), 32'(vecs[i].exp_cmd));
      checkOutput($sformatf("v%0d rx_byte_vld count", i), 32'(byte_cnt - b0), 32'(vecs[i].exp_bytes));
      checkOutput($sformatf("v%0d frm_err count", i), 32'(err_cnt - e0), 32'(vecs[i].exp_err));
      checkOutput($sformatf("v%0d cmd_vld latency", i), 32'(lat_err - l0), 32'h0);
      checkOutput($sformatf("v%0d strobe cmd_wr", i), 32'(last_wr), 32'(vecs[i].exp_wr));
      checkOutput($sformatf("v%0d strobe cmd_addr", i), 32'(last_addr), 32'(vecs[i].exp_addr));
      checkOutput($sformatf("v%0d strobe cmd_wdata", i), 32'(last_wdata), 32'(vecs[i].exp_wdata));
      checkOutput($sformatf("v%0d held cmd_addr", i), 32'(cmd_addr), 32'(vecs[i].exp_addr));
      checkOutput($sformatf("v%0d held cmd_wdata", i), 32'(cmd_wdata), 32'(vecs[i].exp_wdata));
      checkOutput($sformatf("v%0d held rx_byte", i), 32'(rx_byte),
                  32'(vecs[i].b[vecs[i].nbytes - 1]));
    end

    // Short low glitch must be rejected at the start-bit sample.
    b0 = byte_cnt; e0 = err_cnt;
    uart_rx = 1'b0;
    repeat (5) @(negedge clk_sys);
    uart_rx = 1'b1;
    repeat (3 * BIT_CYC) @(negedge clk_sys);
    checkOutput("glitch rx_byte_vld count", 32'(byte_cnt - b0), 32'h0);
    checkOutput("glitch frm_err count", 32'(err_cnt - e0), 32'h0);

    // Reset in the middle of the data byte aborts the frame.
    c0 = cmd_cnt; b0 = byte_cnt;
    sendByte(8'h82, 1'b1);
    repeat (BIT_CYC) @(negedge clk_sys);
    sendByte(8'h12, 1'b1);
    repeat (BIT_CYC) @(negedge clk_sys);
    sendByte(8'h07, 1'b1);
    repeat (BIT_CYC) @(negedge clk_sys);
    uart_rx = 1'b0;
    repeat (BIT_CYC) @(negedge clk_sys);
    for (int i = 0; i < 4; i++) begin
      uart_rx = i[0];
      repeat (BIT_CYC) @(negedge clk_sys);
    end
    rst_sys = 1'b1;
    uart_rx = 1'b1;
    repeat (4) @(negedge clk_sys);
    rst_sys = 1'b0;
    repeat (3 * BIT_CYC) @(negedge clk_sys);
    checkOutput("rst-mid cmd_vld count", 32'(cmd_cnt - c0), 32'h0);
    checkOutput("rst-mid rx_byte_vld count", 32'(byte_cnt - b0), 32'd3);
    checkOutput("rst-mid cmd_addr", 32'(cmd_addr), 32'h0);
    checkOutput("rst-mid cmd_wr", 32'(cmd_wr), 32'h0);
    checkOutput("rst-mid cmd_wdata", 32'(cmd_wdata), 32'h0);
    checkOutput("rst-mid rx_byte", 32'(rx_byte), 32'h0);

    post = '{nbytes: 4, b: {8'h02, 8'h12, 8'h34, 8'h56, 32'h0}, bad_stop: 8'h00, gap: 1,
             to_after: -1, exp_cmd: 1, exp_wr: 1'b0, exp_addr: 16'h1234, exp_wdata: 8'h56,
             exp_bytes: 4, exp_err: 0};
    c0 = cmd_cnt;
    applyStimulus(post);
    checkOutput("post-reset cmd_vld count", 32'(cmd_cnt - c0), 32'(post.exp_cmd));
    checkOutput("post-reset cmd_wr", 32'(last_wr), 32'(post.exp_wr));
    checkOutput("post-reset cmd_addr", 32'(last_addr), 32'(post.exp_addr));
    checkOutput("post-reset cmd_wdata", 32'(last_wdata), 32'(post.exp_wdata));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/uart_cmd_rx.md
# uart_cmd_rx

Receive-side command front end for the board-control path. Deserialises the host UART line (start, 8 data bits LSB first, one spare bit, stop) and assembles 4-byte command frames. Each complete frame is presented to the register/IIC control block as a single-cycle command strobe carrying direction, 16-bit address and 8-bit data.

## Interface
- BIT_CYC, 868: clock cycles per UART bit (100 MHz, 115200 baud); legal range 16..65535.
- TO_CYC, 100000: inter-byte timeout in cycles; a partially assembled frame is discarded when it expires.
- clk_sys  in  1  system clock; all logic on its rising edge.
- rst_sys  in  1  reset; synchronous, active-high.
- uart_rx  in  1  asynchronous serial input, idle high.
- cmd_vld  out  1  one-cycle strobe when a complete, valid frame is received.
- cmd_wr  out  1  1 = write (header 0x82), 0 = read (header 0x02); valid with cmd_vld.
- cmd_addr  out  16  {byte1, byte2}; valid with cmd_vld.
- cmd_wdata  out  8  byte3; valid with cmd_vld. Passed through unchanged for reads.
- frm_err  out  1  one-cycle strobe on a framing error (stop bit sampled 0).
- rx_byte_vld  out  1  one-cycle strobe per correctly received byte (debug).
- rx_byte  out  8  last received byte; valid with rx_byte_vld and held afterwards.

## Operation
- Input conditioning:
  - uart_rx passes through a 2-flop synchroniser (reset value 1).
  - A falling edge on the synchronised signal, detected in IDLE, starts a byte.
- Bit FSM, states IDLE, START, DATA, SPARE, STOP:
  - IDLE -> START on the falling edge. The bit counter loads BIT_CYC/2 - 1.
  - START: at expiry the line is sampled. 0 -> DATA with the counter reloaded to BIT_CYC-1. 1 -> IDLE, treated as a glitch: no strobe, no error.
  - DATA: samples 8 bits at mid-bit, LSB first, into a shift register, then -> SPARE.
  - SPARE: samples one bit and ignores its value, then -> STOP.
  - STOP: the mid-bit sample decides the outcome.
    - Sample 1: rx_byte_vld=1, rx_byte updated, -> IDLE.
    - Sample 0: frm_err=1, byte discarded, frame index cleared, -> IDLE. The next falling edge is accepted only after the line has returned high.
- Frame assembler:
  - Byte index 0..3; the header, address and data registers hold the collected bytes.
  - Index 0: only 0x82 or 0x02 is accepted (index -> 1). Any other byte is dropped and the index stays 0 (resync).
  - Indices 1 and 2: the byte is stored as address high and low.
  - Index 3: the byte is stored as data, cmd_vld is pulsed, and the index -> 0.
- Timeout:
  - The counter is cleared on every rx_byte_vld and runs while the index is nonzero.
  - At TO_CYC the index is cleared, with no strobe.
  - If a byte completes in the same cycle as the timeout, the byte wins: it is processed at the current index and the timeout is ignored.
- No backpressure: the consumer must accept cmd_vld in the cycle it is asserted.
- cmd_addr, cmd_wr and cmd_wdata hold their values until the next cmd_vld.

## Timing
- Reset values:
  - All strobes 0; cmd_wr=0, cmd_addr=0, cmd_wdata=0, rx_byte=0.
  - FSM in IDLE, byte index 0, counters 0, synchroniser flops 1.
- Reset asserted mid-byte or mid-frame aborts everything. No strobe is issued, and reception restarts on the first falling edge after reset is released.
- Sample points fall BIT_CYC/2 + k·BIT_CYC cycles after the detected edge (k = 0 for start … 10 for stop). The detected edge lags the pin by 2–3 cycles because of the synchroniser.
- rx_byte_vld is registered: asserted the cycle after the stop-bit sample.
- cmd_vld is asserted the cycle after rx_byte_vld of byte 3. Outputs change in the same cycle as cmd_vld.
- Back-to-back bytes (stop bit followed immediately by the next start bit) must be received without loss. The FSM returns to IDLE at the stop sample, half a bit before the next start edge.

## Test plan
- Write frame 0x82,0x00,0x02,0x42 at BIT_CYC spacing -> one cmd_vld with cmd_wr=1, cmd_addr=0x0002, cmd_wdata=0x42; four rx_byte_vld pulses.
- Read frame 0x02,0x00,0x85,0x00 sent back-to-back with no idle gap -> cmd_vld with cmd_wr=0, cmd_addr=0x0085, cmd_wdata=0x00.
- Bad header 0x55 followed by write frame 0x82,0x00,0x04,0x55 -> exactly one cmd_vld, with addr 0x0004 and data 0x55.
- Send 0x82,0x00, then idle for TO_CYC+10 cycles, then 0x82,0x00,0x03,0x20 -> one cmd_vld, addr 0x0003, data 0x20; no strobe from the partial frame.
- Stop bit forced 0 on byte 2 of a frame -> frm_err pulse and no cmd_vld. A following valid frame 0x82,0x00,0x06,0x03 produces cmd_vld with addr 0x0006, data 0x03.
- Low glitch of 0.3·BIT_CYC on the line -> no rx_byte_vld and no frm_err. rst_sys asserted during byte 3 -> no cmd_vld, outputs at reset values.
